// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: owns the PC, issues single-outstanding fetch
// requests, and writes the IF/ID register with instructions or NOP bubbles.
module ifetch_ctrl #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h4000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_rd,
  output logic [15:0] imem_addr,
  input  logic        imem_done,
  input  logic [15:0] imem_rdata,
  output logic        ifid_wen,
  output logic [15:0] ifid_pc_out,
  output logic [15:0] ifid_pc_inc,
  output logic [15:0] ifid_instr,
  output logic        ifid_halt
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_HOLD = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic        busy_q, busy_d;
  logic        squash_q, squash_d;
  logic [15:0] buf_instr_q, buf_instr_d;
  logic [15:0] buf_pc_q, buf_pc_d;
  logic        avail;

  function automatic logic is_halt(input logic [15:0] instr);
    return (instr[15:11] == 5'b00000);
  endfunction

  // Next-state and IF/ID outputs; priority is rst > redirect > stall > done
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    busy_d      = busy_q;
    squash_d    = squash_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    avail       = 1'b0;
    imem_rd     = 1'b0;
    imem_addr   = pc_q;
    ifid_wen    = ~stall;
    ifid_instr  = NOP_INSTR;
    ifid_pc_out = pc_q;
    ifid_pc_inc = pc_q + 16'd2;
    ifid_halt   = 1'b0;

    if (rst) begin
      ifid_wen    = 1'b1;
      ifid_pc_out = 16'h0000;
      ifid_pc_inc = 16'h0000;
    end else if (redirect) begin
      ifid_wen    = 1'b1;
      pc_d        = redirect_pc;
      state_d     = S_RUN;
      buf_instr_d = 16'h0000;
      buf_pc_d    = 16'h0000;
      // A response still in flight must be thrown away when it lands
      if (busy_q && !imem_done) begin
        squash_d = 1'b1;
      end else begin
        busy_d   = 1'b0;
        squash_d = 1'b0;
      end
    end else begin
      case (state_q)
        S_RUN: begin
          if (!busy_q) begin
            imem_rd = 1'b1;
            avail   = imem_done;
            busy_d  = ~imem_done;
          end else begin
            avail = imem_done & ~squash_q;
            if (imem_done) begin
              busy_d   = 1'b0;
              squash_d = 1'b0;
            end else begin
              busy_d = 1'b1;
            end
          end
          if (avail) begin
            if (!stall) begin
              ifid_wen   = 1'b1;
              ifid_instr = imem_rdata;
              ifid_halt  = is_halt(imem_rdata);
              if (is_halt(imem_rdata)) begin
                state_d = S_HALT;
              end else begin
                pc_d = pc_q + 16'd2;
              end
            end else begin
              ifid_wen    = 1'b0;
              buf_instr_d = imem_rdata;
              buf_pc_d    = pc_q;
              state_d     = S_HOLD;
            end
          end else begin
            ifid_instr = NOP_INSTR;
          end
        end
        S_HOLD: begin
          ifid_instr  = buf_instr_q;
          ifid_pc_out = buf_pc_q;
          ifid_pc_inc = buf_pc_q + 16'd2;
          ifid_halt   = is_halt(buf_instr_q);
          if (!stall) begin
            if (is_halt(buf_instr_q)) begin
              state_d = S_HALT;
            end else begin
              pc_d    = pc_q + 16'd2;
              state_d = S_RUN;
            end
          end else begin
            state_d = S_HOLD;
          end
        end
        S_HALT: begin
          state_d = S_HALT;
        end
        default: begin
          state_d = S_RUN;
        end
      endcase
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RUN;
      pc_q        <= RESET_PC;
      busy_q      <= 1'b0;
      squash_q    <= 1'b0;
      buf_instr_q <= 16'h0000;
      buf_pc_q    <= 16'h0000;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      busy_q      <= busy_d;
      squash_q    <= squash_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
    end
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Randomized scoreboard bench for ifetch_ctrl: an instruction-memory responder
// with random latency, random stalls/redirects/resets, and a program-order model.
module tb_ifetch_ctrl;

  localparam logic [15:0] NOP = 16'h4000;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic        imem_done;
  logic [15:0] imem_rdata;
  logic        ifid_wen;
  logic [15:0] ifid_pc_out;
  logic [15:0] ifid_pc_inc;
  logic [15:0] ifid_instr;
  logic        ifid_halt;

  ifetch_ctrl dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_rd(imem_rd), .imem_addr(imem_addr),
    .imem_done(imem_done), .imem_rdata(imem_rdata), .ifid_wen(ifid_wen),
    .ifid_pc_out(ifid_pc_out), .ifid_pc_inc(ifid_pc_inc),
    .ifid_instr(ifid_instr), .ifid_halt(ifid_halt)
  );

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] mem [256];
  int          total = 0;
  int          bad   = 0;
  logic        seen_halt = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [7:0] idx;
    idx = a[8:1];
    return mem[idx];
  endfunction

  function automatic logic halt_of(input logic [15:0] w);
    return (w[15:11] == 5'b00000);
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: got=%h want=%h", name, $time, act, req);
    end
  endtask

  // Stimulus, memory responder and expected-stream generation
  initial begin
    logic [15:0] gen_pc, restart_pc, pend_addr, tmp;
    logic        gen_live, restart, pend;
    int          pend_cnt, lat, sel;
    exp_t        e;

    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    imem_done = 1'b0; imem_rdata = 16'h0000;
    for (int i = 0; i < 256; i++) begin
      tmp = 16'($urandom);
      if (tmp == NOP) tmp = 16'h4001;
      if ($urandom_range(0, 19) == 0) tmp[15:11] = 5'b00000;
      mem[i] = tmp;
    end
    gen_pc = 16'h0000; gen_live = 1'b0; restart = 1'b1; restart_pc = 16'h0000;
    pend = 1'b0; pend_cnt = 0; pend_addr = 16'h0000;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      if (restart) begin
        exp_q.delete();
        gen_pc   = restart_pc;
        gen_live = 1'b1;
        restart  = 1'b0;
      end
      while (gen_live && exp_q.size() < 4) begin
        e.pc    = gen_pc;
        e.instr = mem_word(gen_pc);
        exp_q.push_back(e);
        if (halt_of(e.instr)) gen_live = 1'b0;
        gen_pc = gen_pc + 16'd2;
      end
      #1;
      rst      = (cyc < 3) || ($urandom_range(0, 249) == 0);
      stall    = ($urandom_range(0, 3) == 0);
      redirect = !rst && ($urandom_range(0, 14) == 0);
      sel = $urandom_range(0, 3);
      tmp = 16'($urandom);
      redirect_pc = (sel == 0) ? 16'hFFFE : (sel == 1) ? 16'hFFFC : {tmp[15:1], 1'b0};
      imem_done  = 1'b0;
      imem_rdata = 16'($urandom);
      if (rst) begin
        pend = 1'b0; restart = 1'b1; restart_pc = 16'h0000;
      end else if (redirect) begin
        restart = 1'b1; restart_pc = redirect_pc;
      end
      #1;
      if (!rst) begin
        if (pend) begin
          chk("one_outstanding", {15'd0, imem_rd}, 16'h0000);
          pend_cnt--;
          if (pend_cnt == 0) begin
            imem_done  = 1'b1;
            imem_rdata = mem_word(pend_addr);
            pend       = 1'b0;
          end
        end else if (imem_rd) begin
          lat = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
          if (lat == 0) begin
            imem_done  = 1'b1;
            imem_rdata = mem_word(imem_addr);
          end else begin
            pend = 1'b1; pend_cnt = lat; pend_addr = imem_addr;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Monitor: compares IF/ID writes and fetch addresses against the expected stream
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      chk("rst_imem_rd", {15'd0, imem_rd}, 16'h0000);
      chk("rst_wen", {15'd0, ifid_wen}, 16'h0001);
      chk("rst_instr", ifid_instr, NOP);
      chk("rst_pc_out", ifid_pc_out, 16'h0000);
      chk("rst_pc_inc", ifid_pc_inc, 16'h0000);
      chk("rst_halt", {15'd0, ifid_halt}, 16'h0000);
      seen_halt = 1'b0;
    end else begin
      chk("wen_vs_stall", {15'd0, ifid_wen}, {15'd0, (!stall || redirect)});
      if (redirect) begin
        chk("redir_instr", ifid_instr, NOP);
        chk("redir_halt", {15'd0, ifid_halt}, 16'h0000);
        chk("redir_no_rd", {15'd0, imem_rd}, 16'h0000);
        seen_halt = 1'b0;
      end else begin
        if (seen_halt) chk("halt_no_rd", {15'd0, imem_rd}, 16'h0000);
        if (imem_rd && exp_q.size() > 0) chk("fetch_addr", imem_addr, exp_q[0].pc);
        if (ifid_wen) begin
          if (ifid_instr == NOP) begin
            chk("bubble_halt", {15'd0, ifid_halt}, 16'h0000);
            if (exp_q.size() > 0) begin
              chk("bubble_pc_out", ifid_pc_out, exp_q[0].pc);
              chk("bubble_pc_inc", ifid_pc_inc, exp_q[0].pc + 16'd2);
            end
          end else if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write at %0t: got pc=%h instr=%h want no write",
                     $time, ifid_pc_out, ifid_instr);
          end else begin
            e = exp_q.pop_front();
            chk("wr_pc_out", ifid_pc_out, e.pc);
            chk("wr_pc_inc", ifid_pc_inc, e.pc + 16'd2);
            chk("wr_instr", ifid_instr, e.instr);
            chk("wr_halt", {15'd0, ifid_halt}, {15'd0, halt_of(e.instr)});
            if (halt_of(e.instr)) seen_halt = 1'b1;
          end
        end
      end
    end
  end

endmodule
